// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width, FIFO depth and pointer sizing.
package uart_pkg;

  // Width of one UART data byte.
  localparam int DATA_BIT_DEFAULT = 8;

  // Default depth for the receive FIFO, and later the transmit FIFO.
  localparam int UART_FIFO_DEPTH = 16;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointer width for the default depth.
  localparam int UART_FIFO_PTR_W = ptrWidth(UART_FIFO_DEPTH);

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port and one asynchronous
// read port. Contents are deliberately not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_BIT_DEFAULT,
  parameter int DEPTH = UART_FIFO_DEPTH,
  localparam int AW = ptrWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] memQ [DEPTH];

  // Store the incoming word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      memQ[wr_addr] <= wr_data;
    end
  end

  assign rd_data = memQ[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular FIFO with a show-ahead
// valid/ready read port, occupancy flags and a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BIT    = DATA_BIT_DEFAULT,
  parameter int DEPTH       = UART_FIFO_DEPTH,
  parameter int AFULL_LEVEL = 12,
  localparam int AW = ptrWidth(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_BIT-1:0] rx_data,
  input  logic                rx_done,
  output logic [DATA_BIT-1:0] rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [CW-1:0]       count,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                overrun,
  input  logic                overrun_clr
);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          readFire;
  logic          writeAccept;
  logic          writeDrop;

  // Flags come straight from the occupancy register.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_LEVEL));
  assign rd_valid    = !empty;
  assign count       = count_q;
  assign overrun     = overrun_q;

  // A full FIFO can still take a byte when a read frees a slot this cycle.
  assign readFire    = rd_valid && rd_ready;
  assign writeAccept = rx_done && (!full || readFire);
  assign writeDrop   = rx_done && !writeAccept;

  uart_fifo_mem #(
    .WIDTH (DATA_BIT),
    .DEPTH (DEPTH)
  ) uMem (
    .clk     (clk),
    .wr_en   (writeAccept),
    .wr_addr (wrPtr_q),
    .wr_data (rx_data),
    .rd_addr (rdPtr_q),
    .rd_data (rd_data)
  );

  // Next-state for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (writeAccept) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (readFire) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end

    case ({writeAccept, readFire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (writeDrop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // State registers; reset empties the FIFO but leaves memory contents alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the driver keeps a queue-level model of
// the FIFO and pushes expected read bytes; a negedge monitor checks rd_data.
module tb_uart_rx_fifo;

  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DB-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic [DB-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  int            total = 0;
  int            bad = 0;
  logic [DB-1:0] expQ [$];
  int            mCount = 0;
  bit            mOvr = 1'b0;

  uart_rx_fifo #(
    .DATA_BIT    (DB),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare status outputs against the model occupancy and overrun state.
  task automatic checkOutput();
    check("count", 32'(count), 32'(mCount));
    check("empty", 32'(empty), 32'(mCount == 0));
    check("full", 32'(full), 32'(mCount == DEPTH));
    check("almost_full", 32'(almost_full), 32'(mCount >= AFL));
    check("rd_valid", 32'(rd_valid), 32'(mCount != 0));
    check("overrun", 32'(overrun), 32'(mOvr));
  endtask

  // One clock of stimulus; called at posedge+1 and returns at the next posedge+1.
  task automatic applyStimulus(input bit wr, input logic [DB-1:0] d, input bit rr, input bit clr);
    bit rdFire;
    bit wAcc;
    rx_done     = wr;
    rx_data     = d;
    rd_ready    = rr;
    overrun_clr = clr;
    rdFire = (mCount > 0) && rr;
    wAcc   = wr && ((mCount < DEPTH) || rdFire);
    if (wAcc) expQ.push_back(d);
    mCount = mCount + (wAcc ? 1 : 0) - (rdFire ? 1 : 0);
    if (wr && !wAcc) mOvr = 1'b1;
    else if (clr) mOvr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic modelReset();
    expQ.delete();
    mCount = 0;
    mOvr = 1'b0;
  endtask

  // Monitor: whenever a byte is presented it must be the oldest expected one.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      if (expQ.size() == 0) begin
        check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        check("rd_data", 32'(rd_data), 32'(expQ[0]));
        if (rd_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b1;

    // Single write then read
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    check("rd_data_a5", 32'(rd_data), 32'h0A5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill, partial drain, refill across the wrap point
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 16; i < 24; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);

    // Overrun while full, then clear
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous read: write accepted
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);

    // Dropped write coinciding with clear: set wins
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain everything, ending with 0x55
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Write while empty with rd_ready high: only the write happens
    applyStimulus(1'b1, 8'h42, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with varying read pressure
    for (int i = 0; i < 900; i++) begin
      int rdPct;
      rdPct = (i < 300) ? 30 : ((i < 600) ? 80 : 50);
      applyStimulus(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < rdPct),
                    ($urandom_range(0, 99) < 5));
    end
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);

    // Reset mid-operation with data stored and overrun set
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    reset = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    check("rd_data_3c", 32'(rd_data), 32'h03C);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check("scoreboard_final", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
